// File: rtl/add_pkg.sv
// Shared definitions for the adder chain: sum width, sum type and the
// accumulator FSM state encoding.
package add_pkg;

    localparam int SUM_W = 5;

    typedef logic [SUM_W-1:0] sum_t;

    typedef enum logic {ACC, HOLD} acc_state_e;

    // Accumulator width that cannot overflow for a batch of 'batch' sums.
    function automatic int acc_width(input int batch);
        return SUM_W + $clog2(batch);
    endfunction

endpackage

// File: rtl/add_sum_acc_if.sv
// Valid/ready bus between the adder stage, the sum accumulator and the
// result consumer. master = producer/consumer side, slave = accumulator.
interface add_sum_acc_if #(
    parameter int BATCH = 4
) ();
    import add_pkg::*;

    localparam int ACC_W = acc_width(BATCH);

    logic             in_valid;
    logic             in_ready;
    sum_t             in_sum;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    sum_t             out_max;

    modport master (
        output in_valid, in_sum, out_ready,
        input  in_ready, out_valid, out_acc, out_max
    );

    modport slave (
        input  in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_acc, out_max
    );

endinterface

// File: rtl/add_sum_acc.sv
// Batch accumulator for adder sums: collects BATCH samples, then presents
// their total and maximum on a registered valid/ready output until taken.
module add_sum_acc
    import add_pkg::*;
#(
    parameter int BATCH = 4
) (
    input logic         clk,
    input logic         rst_n,
    input logic         clr,
    add_sum_acc_if.slave bus
);

    localparam int ACC_W = acc_width(BATCH);
    localparam int CNT_W = $clog2(BATCH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BATCH - 1);

    acc_state_e       state;
    acc_state_e       state_nxt;
    logic             in_ready_c;

    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    sum_t             max_r;

    logic             out_valid_r;
    logic [ACC_W-1:0] out_acc_r;
    sum_t             out_max_r;

    logic             accept;
    logic             last;
    logic             take;
    logic [ACC_W-1:0] acc_upd;
    sum_t             max_upd;

    function automatic sum_t max_sum(input sum_t a, input sum_t b);
        return (a > b) ? a : b;
    endfunction

    assign accept  = bus.in_valid && in_ready_c;
    assign last    = accept && (cnt_r == CNT_LAST);
    assign take    = out_valid_r && bus.out_ready;
    assign acc_upd = acc_r + ACC_W'(bus.in_sum);
    assign max_upd = max_sum(bus.in_sum, max_r);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: clr wins over every handshake
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ACC;
        end else begin
            unique case (state)
                ACC:  if (last) state_nxt = HOLD;
                HOLD: if (take) state_nxt = ACC;
                default: state_nxt = ACC;
            endcase
        end
    end

    // FSM outputs: in_ready decodes the state register only
    always_comb begin
        in_ready_c = 1'b0;
        unique case (state)
            ACC:     in_ready_c = 1'b1;
            HOLD:    in_ready_c = 1'b0;
            default: in_ready_c = 1'b0;
        endcase
    end

    // Batch accumulation and registered result; clr discards the cycle's transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= '0;
            cnt_r       <= '0;
            max_r       <= '0;
            out_valid_r <= 1'b0;
            out_acc_r   <= '0;
            out_max_r   <= '0;
        end else if (clr) begin
            acc_r       <= '0;
            cnt_r       <= '0;
            max_r       <= '0;
            out_valid_r <= 1'b0;
            out_acc_r   <= '0;
            out_max_r   <= '0;
        end else begin
            if (take) begin
                out_valid_r <= 1'b0;
            end
            if (last) begin
                out_acc_r   <= acc_upd;
                out_max_r   <= max_upd;
                out_valid_r <= 1'b1;
                acc_r       <= '0;
                cnt_r       <= '0;
                max_r       <= '0;
            end else if (accept) begin
                acc_r <= acc_upd;
                cnt_r <= cnt_r + 1'b1;
                max_r <= max_upd;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_r;
    assign bus.out_acc   = out_acc_r;
    assign bus.out_max   = out_max_r;

endmodule

// File: tb/tb_add_sum_acc.sv
// Directed bench for add_sum_acc: batches, backpressure, gaps, clr and async reset.
module tb_add_sum_acc;

    logic clk;
    logic rst_n;
    logic clr;
    int   errors;
    int   checks;

    add_sum_acc_if #(.BATCH(4)) bus ();

    add_sum_acc #(.BATCH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int s);
        bus.in_valid = 1'b1;
        bus.in_sum   = 5'(s);
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        clr   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_acc", 32'(bus.out_acc), 0);
        chk("rst_out_max", 32'(bus.out_max), 0);
        rst_n = 1'b1;
        tick();

        // Basic batch 8,8,7,14
        send(8);
        send(8);
        send(7);
        chk("basic_not_yet", 32'(bus.out_valid), 0);
        send(14);
        chk("basic_valid", 32'(bus.out_valid), 1);
        chk("basic_acc", 32'(bus.out_acc), 37);
        chk("basic_max", 32'(bus.out_max), 14);
        chk("basic_ready_low", 32'(bus.in_ready), 0);
        tick();
        chk("basic_handoff", 32'(bus.out_valid), 0);
        chk("basic_ready_back", 32'(bus.in_ready), 1);
        chk("basic_acc_kept", 32'(bus.out_acc), 37);

        // Full-scale batch with backpressure
        bus.out_ready = 1'b0;
        send(31);
        send(31);
        send(31);
        send(31);
        chk("full_valid", 32'(bus.out_valid), 1);
        chk("full_acc", 32'(bus.out_acc), 124);
        chk("full_max", 32'(bus.out_max), 31);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sum   = 5'(17 + i);
            tick();
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_ready", 32'(bus.in_ready), 0);
            chk("bp_acc", 32'(bus.out_acc), 124);
            chk("bp_max", 32'(bus.out_max), 31);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release", 32'(bus.out_valid), 0);
        send(1);
        send(2);
        send(3);
        send(4);
        chk("bp_next_valid", 32'(bus.out_valid), 1);
        chk("bp_next_acc", 32'(bus.out_acc), 10);
        chk("bp_next_max", 32'(bus.out_max), 4);
        tick();

        // Input gaps: 5,_,_,6,_,2,9
        send(5);
        bus.in_sum = 5'd30;
        tick();
        tick();
        send(6);
        tick();
        send(2);
        chk("gap_not_yet", 32'(bus.out_valid), 0);
        send(9);
        chk("gap_valid", 32'(bus.out_valid), 1);
        chk("gap_acc", 32'(bus.out_acc), 22);
        chk("gap_max", 32'(bus.out_max), 9);
        tick();

        // clr mid-batch discards partial batch and the clr-cycle sample
        send(10);
        send(20);
        clr = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sum   = 5'd3;
        tick();
        clr = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_out_acc", 32'(bus.out_acc), 0);
        chk("clr_out_max", 32'(bus.out_max), 0);
        chk("clr_ready", 32'(bus.in_ready), 1);
        bus.out_ready = 1'b0;
        send(1);
        send(1);
        chk("clr_not_early", 32'(bus.out_valid), 0);
        send(1);
        send(1);
        chk("clr_valid", 32'(bus.out_valid), 1);
        chk("clr_acc", 32'(bus.out_acc), 4);
        chk("clr_max", 32'(bus.out_max), 1);

        // clr in HOLD drops the pending result even with out_ready high
        clr = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_hold_valid", 32'(bus.out_valid), 0);
        chk("clr_hold_acc", 32'(bus.out_acc), 0);
        chk("clr_hold_ready", 32'(bus.in_ready), 1);

        // Async reset in HOLD
        bus.out_ready = 1'b0;
        send(3);
        send(3);
        send(3);
        send(3);
        chk("hold_acc_pre", 32'(bus.out_acc), 12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hold_valid", 32'(bus.out_valid), 0);
        chk("arst_hold_acc", 32'(bus.out_acc), 0);
        chk("arst_hold_max", 32'(bus.out_max), 0);
        chk("arst_hold_ready", 32'(bus.in_ready), 1);
        rst_n = 1'b1;
        tick();

        // Async reset mid-batch loses the partial batch
        bus.out_ready = 1'b1;
        send(7);
        send(7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mid_ready", 32'(bus.in_ready), 1);
        rst_n = 1'b1;
        tick();
        send(2);
        send(2);
        send(2);
        chk("arst_not_early", 32'(bus.out_valid), 0);
        send(2);
        chk("arst_valid", 32'(bus.out_valid), 1);
        chk("arst_acc", 32'(bus.out_acc), 8);
        chk("arst_max", 32'(bus.out_max), 2);
        tick();
        chk("arst_done", 32'(bus.out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
